// File: rtl/reg_write_queue_pkg.sv
// Shared sizing for the register write queue and the downstream 32-bit register.
package reg_write_queue_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

endpackage

// File: rtl/reg_write_queue_fifo_mem.sv
// Queue storage: DEPTH x WIDTH array, one synchronous write port, one async read port.
module reg_write_queue_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; the top masks the read data while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_write_queue.sv
// Buffers write requests and feeds one per cycle into a d/enable register,
// counting requests rejected while full.
module reg_write_queue
    import reg_write_queue_pkg::*;
#(
    parameter int  WIDTH  = WIDTH_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  DROP_W = DROP_W_DEF,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_enable,
    output logic [WIDTH-1:0]  out_d,
    output logic [PTR_W:0]    count,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic [DROP_W-1:0] drops;
    logic [WIDTH-1:0]  head;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready, and ready never depends on valid.
    assign empty      = (cnt == '0);
    assign full       = (cnt == CNT_FULL);
    assign in_ready   = reset && !full;
    assign out_enable = !empty && out_ready;
    assign out_d      = empty ? '0 : head;
    assign count      = cnt;
    assign drop_count = drops;

    assign push = in_valid && in_ready;
    assign pop  = out_enable;
    assign drop = in_valid && !in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Full/empty come from the occupancy count; pointers alone are ambiguous.
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops <= '0;
        end else if (drop && (drops != '1)) begin
            drops <= drops + 1'b1;
        end
    end

    reg_write_queue_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue: queue model checked every cycle plus literal spot checks.
module tb_reg_write_queue;

    localparam int DEPTH = 4;
    localparam int DMAX  = 255;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_ready;
    logic        out_enable;
    logic [31:0] out_d;
    logic [2:0]  count;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    int          exp_drop = 0;
    logic [31:0] exp_reg  = 0;
    logic [31:0] reg_q    = 0;

    reg_write_queue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_enable (out_enable),
        .out_d      (out_d),
        .count      (count),
        .drop_count (drop_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // downstream enabled register fed by the queue
    always @(posedge clk) begin
        if (out_enable) reg_q <= out_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver: new inputs 1 time unit after the rising edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #2;
    endtask

    // scoreboard: compare on the falling edge, then advance the model across the next rising edge
    always @(negedge clk) begin
        logic        e_ready;
        logic        e_en;
        logic [31:0] e_d;
        if (!reset) begin
            exp_q.delete();
            exp_drop = 0;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_enable", {31'd0, out_enable}, 32'd0);
            chk("rst_count", {29'd0, count}, 32'd0);
            chk("rst_out_d", out_d, 32'd0);
            chk("rst_drop", {24'd0, drop_count}, 32'd0);
        end else begin
            e_ready = (exp_q.size() < DEPTH);
            e_en    = (exp_q.size() != 0) && out_ready;
            e_d     = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, e_ready});
            chk("m_out_enable", {31'd0, out_enable}, {31'd0, e_en});
            chk("m_out_d", out_d, e_d);
            chk("m_count", {29'd0, count}, exp_q.size());
            chk("m_drop", {24'd0, drop_count}, exp_drop);
            chk("m_reg_q", reg_q, exp_reg);
            if (e_en) exp_reg = exp_q.pop_front();
            if (in_valid && e_ready) exp_q.push_back(in_data);
            else if (in_valid && exp_drop < DMAX) exp_drop++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd5;
        out_ready = 1'b0;

        // reset held with a request present
        cyc(1, 5, 0);
        cyc(1, 5, 0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_count", {29'd0, count}, 32'd0);
        chk("reset_out_enable", {31'd0, out_enable}, 32'd0);
        chk("reset_drop", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        #2;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // single write
        cyc(1, 88, 1);
        chk("single_no_bypass", {31'd0, out_enable}, 32'd0);
        cyc(0, 0, 1);
        chk("single_out_enable", {31'd0, out_enable}, 32'd1);
        chk("single_out_d", out_d, 32'd88);
        cyc(0, 0, 1);
        chk("single_count", {29'd0, count}, 32'd0);
        chk("single_reg_q", reg_q, 32'd88);

        // burst with backpressure, then drain
        for (int i = 1; i <= 5; i++) cyc(1, i, 0);
        chk("burst_count", {29'd0, count}, 32'd4);
        chk("burst_in_ready", {31'd0, in_ready}, 32'd0);
        cyc(0, 0, 0);
        chk("burst_drop", {24'd0, drop_count}, 32'd1);
        cyc(0, 0, 1);
        chk("drain_d1", out_d, 32'd1);
        cyc(0, 0, 1);
        chk("drain_d2", out_d, 32'd2);
        chk("drain_ready_back", {31'd0, in_ready}, 32'd1);
        cyc(0, 0, 1);
        chk("drain_d3", out_d, 32'd3);
        cyc(0, 0, 1);
        chk("drain_d4", out_d, 32'd4);
        cyc(0, 0, 0);
        chk("drain_reg_q", reg_q, 32'd4);
        chk("drain_count", {29'd0, count}, 32'd0);

        // simultaneous push and pop at count 2
        cyc(1, 20, 0);
        cyc(1, 21, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 30 + i, 1);
            chk("simul_count", {29'd0, count}, 32'd2);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        chk("simul_empty", {29'd0, count}, 32'd0);
        chk("simul_reg_q", reg_q, 32'd35);

        // pointer wrap-around
        for (int i = 0; i < 10; i++) cyc(1, 100 + i, 1);
        chk("wrap_count", {29'd0, count}, 32'd1);
        chk("wrap_head", out_d, 32'd108);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        chk("wrap_reg_q", reg_q, 32'd109);

        // drop counter saturation
        for (int i = 0; i < 4; i++) cyc(1, 200 + i, 0);
        for (int i = 0; i < 260; i++) cyc(1, 999, 0);
        cyc(0, 0, 0);
        chk("sat_drop", {24'd0, drop_count}, 32'd255);
        chk("sat_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        chk("sat_reg_q", reg_q, 32'd203);

        // reset pulse between edges with three entries queued
        cyc(1, 50, 0);
        cyc(1, 51, 0);
        cyc(1, 52, 0);
        cyc(0, 0, 0);
        chk("mid_count_pre", {29'd0, count}, 32'd3);
        out_ready = 1'b1;
        #1;
        chk("mid_enable_pre", {31'd0, out_enable}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_count", {29'd0, count}, 32'd0);
        chk("mid_enable", {31'd0, out_enable}, 32'd0);
        chk("mid_drop", {24'd0, drop_count}, 32'd0);
        exp_q.delete();
        exp_drop = 0;
        reset = 1'b1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("mid_reg_kept", reg_q, 32'd203);
        cyc(1, 77, 1);
        cyc(0, 0, 1);
        chk("post_out_d", out_d, 32'd77);
        cyc(0, 0, 0);
        chk("post_reg_q", reg_q, 32'd77);
        cyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
